// File: rtl/ps2_pkg.sv
// Shared types, PS/2 set-2 constants and scancode tables for the ASCII-to-scancode encoder.
package ps2_pkg;

  typedef enum logic [1:0] {MOD_NONE, MOD_SHIFT, MOD_CTRL, MOD_EXT} sc_mod_t;
  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_GAP} state_t;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_LCTRL  = 8'h14;

  // Index of the final byte of a sequence; the step counter stops here.
  function automatic logic [2:0] seq_last(input sc_mod_t m, input logic brk);
    logic [2:0] r;
    case (m)
      MOD_NONE:  r = brk ? 3'd2 : 3'd0;
      MOD_EXT:   r = brk ? 3'd4 : 3'd1;
      default:   r = brk ? 3'd5 : 3'd1;
    endcase
    return r;
  endfunction

  // Byte emitted at a given step; without break codes only the leading steps are ever reached.
  function automatic logic [7:0] seq_byte(input sc_mod_t m, input logic [2:0] step,
                                          input logic [7:0] k);
    logic [7:0] mb;
    logic [7:0] b;
    mb = (m == MOD_CTRL) ? SC_LCTRL : SC_LSHIFT;
    b  = k;
    case (m)
      MOD_NONE: if (step == 3'd1) b = SC_BREAK;
      MOD_EXT: begin
        case (step)
          3'd0, 3'd2: b = SC_EXT;
          3'd3:       b = SC_BREAK;
          default:    b = k;
        endcase
      end
      default: begin
        case (step)
          3'd0, 3'd5: b = mb;
          3'd2, 3'd4: b = SC_BREAK;
          default:    b = k;
        endcase
      end
    endcase
    return b;
  endfunction

  function automatic logic [7:0] letter_sc(input logic [4:0] idx);
    logic [7:0] r;
    case (idx)
      5'd0:  r = 8'h1C;  5'd1:  r = 8'h32;  5'd2:  r = 8'h21;  5'd3:  r = 8'h23;
      5'd4:  r = 8'h24;  5'd5:  r = 8'h2B;  5'd6:  r = 8'h34;  5'd7:  r = 8'h33;
      5'd8:  r = 8'h43;  5'd9:  r = 8'h3B;  5'd10: r = 8'h42;  5'd11: r = 8'h4B;
      5'd12: r = 8'h3A;  5'd13: r = 8'h31;  5'd14: r = 8'h44;  5'd15: r = 8'h4D;
      5'd16: r = 8'h15;  5'd17: r = 8'h2D;  5'd18: r = 8'h1B;  5'd19: r = 8'h2C;
      5'd20: r = 8'h3C;  5'd21: r = 8'h2A;  5'd22: r = 8'h1D;  5'd23: r = 8'h22;
      5'd24: r = 8'h35;  5'd25: r = 8'h1A;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] digit_sc(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0: r = 8'h45;  4'd1: r = 8'h16;  4'd2: r = 8'h1E;  4'd3: r = 8'h26;
      4'd4: r = 8'h25;  4'd5: r = 8'h2E;  4'd6: r = 8'h36;  4'd7: r = 8'h3D;
      4'd8: r = 8'h3E;  4'd9: r = 8'h46;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] fkey_sc(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0: r = 8'h05;  4'd1: r = 8'h06;  4'd2:  r = 8'h04;  4'd3:  r = 8'h0C;
      4'd4: r = 8'h03;  4'd5: r = 8'h0B;  4'd6:  r = 8'h83;  4'd7:  r = 8'h0A;
      4'd8: r = 8'h01;  4'd9: r = 8'h09;  4'd10: r = 8'h78;  4'd11: r = 8'h07;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] ext_sc(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0: r = 8'h75;  4'd1: r = 8'h74;  4'd2: r = 8'h72;  4'd3: r = 8'h6B;
      4'd4: r = 8'h6C;  4'd5: r = 8'h69;  4'd6: r = 8'h7D;  4'd7: r = 8'h7A;
      4'd8: r = 8'h70;  4'd9: r = 8'h71;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_ascii_sc_lut.sv
// Combinational ASCII/extended-key byte to {hit, modifier, set-2 key code} lookup.
module ps2_ascii_sc_lut
  import ps2_pkg::*;
(
  input  logic [7:0] ascii_i,
  output logic       hit_o,
  output sc_mod_t    mod_o,
  output logic [7:0] code_o
);

  always_comb begin
    hit_o  = 1'b1;
    mod_o  = MOD_NONE;
    code_o = 8'h00;
    if (ascii_i >= 8'h61 && ascii_i <= 8'h7A) begin
      code_o = letter_sc(5'(ascii_i - 8'h61));
    end else if (ascii_i >= 8'h41 && ascii_i <= 8'h5A) begin
      mod_o  = MOD_SHIFT;
      code_o = letter_sc(5'(ascii_i - 8'h41));
    end else if (ascii_i >= 8'h01 && ascii_i <= 8'h1A &&
                 ascii_i != 8'h08 && ascii_i != 8'h09 && ascii_i != 8'h0D) begin
      // BS, TAB and CR have dedicated keys, so they are not sent as ctrl-letters.
      mod_o  = MOD_CTRL;
      code_o = letter_sc(5'(ascii_i - 8'h01));
    end else if (ascii_i >= 8'h30 && ascii_i <= 8'h39) begin
      code_o = digit_sc(4'(ascii_i - 8'h30));
    end else if (ascii_i >= 8'h90 && ascii_i <= 8'h99) begin
      mod_o  = MOD_EXT;
      code_o = ext_sc(4'(ascii_i - 8'h90));
    end else if (ascii_i >= 8'hA1 && ascii_i <= 8'hAC) begin
      code_o = fkey_sc(4'(ascii_i - 8'hA1));
    end else begin
      case (ascii_i)
        8'h20: code_o = 8'h29;
        8'h09: code_o = 8'h0D;
        8'h0D: code_o = 8'h5A;
        8'h08: code_o = 8'h66;
        8'h1B: code_o = 8'h76;
        8'h7F: code_o = 8'h71;
        8'h60: code_o = 8'h0E;
        8'h2D: code_o = 8'h4E;
        8'h3D: code_o = 8'h55;
        8'h5B: code_o = 8'h54;
        8'h5D: code_o = 8'h5B;
        8'h5C: code_o = 8'h5D;
        8'h3B: code_o = 8'h4C;
        8'h27: code_o = 8'h52;
        8'h2C: code_o = 8'h41;
        8'h2E: code_o = 8'h49;
        8'h2F: code_o = 8'h4A;
        8'h7E: begin mod_o = MOD_SHIFT; code_o = 8'h0E; end
        8'h21: begin mod_o = MOD_SHIFT; code_o = 8'h16; end
        8'h40: begin mod_o = MOD_SHIFT; code_o = 8'h1E; end
        8'h23: begin mod_o = MOD_SHIFT; code_o = 8'h26; end
        8'h24: begin mod_o = MOD_SHIFT; code_o = 8'h25; end
        8'h25: begin mod_o = MOD_SHIFT; code_o = 8'h2E; end
        8'h5E: begin mod_o = MOD_SHIFT; code_o = 8'h36; end
        8'h26: begin mod_o = MOD_SHIFT; code_o = 8'h3D; end
        8'h2A: begin mod_o = MOD_SHIFT; code_o = 8'h3E; end
        8'h28: begin mod_o = MOD_SHIFT; code_o = 8'h46; end
        8'h29: begin mod_o = MOD_SHIFT; code_o = 8'h45; end
        8'h5F: begin mod_o = MOD_SHIFT; code_o = 8'h4E; end
        8'h2B: begin mod_o = MOD_SHIFT; code_o = 8'h55; end
        8'h7B: begin mod_o = MOD_SHIFT; code_o = 8'h54; end
        8'h7D: begin mod_o = MOD_SHIFT; code_o = 8'h5B; end
        8'h7C: begin mod_o = MOD_SHIFT; code_o = 8'h5D; end
        8'h3A: begin mod_o = MOD_SHIFT; code_o = 8'h4C; end
        8'h22: begin mod_o = MOD_SHIFT; code_o = 8'h52; end
        8'h3C: begin mod_o = MOD_SHIFT; code_o = 8'h41; end
        8'h3E: begin mod_o = MOD_SHIFT; code_o = 8'h49; end
        8'h3F: begin mod_o = MOD_SHIFT; code_o = 8'h4A; end
        default: hit_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_ascii_to_scan.sv
// Turns one accepted ASCII/extended key byte into the full PS/2 set-2 make/break byte sequence.
module ps2_ascii_to_scan
  import ps2_pkg::*;
#(
  parameter int BREAK_EN = 1,
  parameter int IDLE_GAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ascii,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic [7:0] sc,
  output logic       sc_valid,
  input  logic       sc_ready,
  output logic       busy,
  output logic       unmapped,
  output logic [1:0] state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid & ready; once sc_valid
  // rises, sc stays stable until that transfer, and ready never depends on valid.
  localparam logic BRK = (BREAK_EN != 0);
  localparam int GW = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  state_t     state_q, state_d;
  logic [2:0] step_q, step_d;
  sc_mod_t    mod_q, mod_d;
  logic [7:0] code_q, code_d;
  logic [7:0] sc_q, sc_d;
  logic       sc_valid_q, sc_valid_d;
  logic       unmapped_q, unmapped_d;
  logic [GW-1:0] gap_q, gap_d;

  logic       lut_hit;
  sc_mod_t    lut_mod;
  logic [7:0] lut_code;
  logic       accept;

  ps2_ascii_sc_lut u_lut (
    .ascii_i (ascii),
    .hit_o   (lut_hit),
    .mod_o   (lut_mod),
    .code_o  (lut_code)
  );

  assign ascii_ready = (state_q == ST_IDLE) & ~rst;
  assign accept      = ascii_valid & ascii_ready;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    mod_d      = mod_q;
    code_d     = code_q;
    sc_d       = sc_q;
    sc_valid_d = sc_valid_q;
    unmapped_d = 1'b0;
    gap_d      = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (lut_hit) begin
            state_d    = ST_EMIT;
            mod_d      = lut_mod;
            code_d     = lut_code;
            step_d     = 3'd0;
            sc_d       = seq_byte(lut_mod, 3'd0, lut_code);
            sc_valid_d = 1'b1;
          end else begin
            unmapped_d = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (sc_valid_q && sc_ready) begin
          if (step_q == seq_last(mod_q, BRK)) begin
            sc_valid_d = 1'b0;
            step_d     = 3'd0;
            gap_d      = '0;
            state_d    = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;
          end else begin
            step_d = step_q + 3'd1;
            sc_d   = seq_byte(mod_q, step_q + 3'd1, code_q);
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      step_q     <= 3'd0;
      mod_q      <= MOD_NONE;
      code_q     <= 8'h00;
      sc_q       <= 8'h00;
      sc_valid_q <= 1'b0;
      unmapped_q <= 1'b0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      mod_q      <= mod_d;
      code_q     <= code_d;
      sc_q       <= sc_d;
      sc_valid_q <= sc_valid_d;
      unmapped_q <= unmapped_d;
      gap_q      <= gap_d;
    end
  end

  assign sc        = sc_q;
  assign sc_valid  = sc_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign unmapped  = unmapped_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ps2_ascii_to_scan.sv
// Bench for ps2_ascii_to_scan: vector table, handshake corner cases and a full 256-code round trip.
module tb_ps2_ascii_to_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ascii, ascii1, sc, sc1;
  logic       ascii_valid, ascii_valid1, ascii_ready, ascii_ready1;
  logic       sc_valid, sc_valid1, sc_ready, sc_ready1;
  logic       busy, busy1, unmapped, unmapped1;
  logic [1:0] state_dbg, state_dbg1;

  always #5 clk = ~clk;

  ps2_ascii_to_scan #(.BREAK_EN(1), .IDLE_GAP(0)) dut (
    .clk(clk), .rst(rst), .ascii(ascii), .ascii_valid(ascii_valid), .ascii_ready(ascii_ready),
    .sc(sc), .sc_valid(sc_valid), .sc_ready(sc_ready), .busy(busy), .unmapped(unmapped),
    .state_dbg(state_dbg)
  );

  ps2_ascii_to_scan #(.BREAK_EN(0), .IDLE_GAP(3)) dut1 (
    .clk(clk), .rst(rst), .ascii(ascii1), .ascii_valid(ascii_valid1), .ascii_ready(ascii_ready1),
    .sc(sc1), .sc_valid(sc_valid1), .sc_ready(sc_ready1), .busy(busy1), .unmapped(unmapped1),
    .state_dbg(state_dbg1)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  bit sb_on = 1'b1;
  bit rand_bp = 1'b0;

  // Reference decoder tables (scan-to-ASCII direction).
  logic [7:0] plain_ch [48] = '{
    8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69, 8'h6A, 8'h6B, 8'h6C,
    8'h6D, 8'h6E, 8'h6F, 8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78,
    8'h79, 8'h7A, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
    8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F, 8'h20};
  logic [7:0] shift_ch [47] = '{
    8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'h4A, 8'h4B, 8'h4C,
    8'h4D, 8'h4E, 8'h4F, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58,
    8'h59, 8'h5A, 8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28,
    8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};
  logic [7:0] plain_sc [48] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B,
    8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
    8'h35, 8'h1A, 8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
    8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A, 8'h29};
  logic [7:0] spec_sc [17] = '{8'h0D, 8'h5A, 8'h66, 8'h76, 8'h71, 8'h05, 8'h06, 8'h04, 8'h0C,
    8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
  logic [7:0] spec_ch [17] = '{8'h09, 8'h0D, 8'h08, 8'h1B, 8'h7F, 8'hA1, 8'hA2, 8'hA3, 8'hA4,
    8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9, 8'hAA, 8'hAB, 8'hAC};
  logic [7:0] ext_tab [10] = '{8'h75, 8'h74, 8'h72, 8'h6B, 8'h6C, 8'h69, 8'h7D, 8'h7A,
    8'h70, 8'h71};

  typedef struct packed {
    logic [7:0]      ch;
    logic [2:0]      len;
    logic [5:0][7:0] b;   // b[5] is the first byte on the wire
  } vec_t;

  vec_t vecs [14];
  vec_t vecs1 [3];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic bit is_mapped(input logic [7:0] c);
    return (c >= 8'h01 && c <= 8'h1B) || (c >= 8'h20 && c <= 8'h7F) ||
           (c >= 8'h90 && c <= 8'h99) || (c >= 8'hA1 && c <= 8'hAC);
  endfunction

  function automatic int lk_plain(input logic [7:0] k);
    for (int i = 0; i < 48; i++) if (plain_sc[i] == k) return int'(plain_ch[i]);
    for (int i = 0; i < 17; i++) if (spec_sc[i] == k) return int'(spec_ch[i]);
    return -1;
  endfunction

  function automatic int lk_shift(input logic [7:0] k);
    for (int i = 0; i < 47; i++) if (plain_sc[i] == k) return int'(shift_ch[i]);
    return -1;
  endfunction

  function automatic int lk_ctrl(input logic [7:0] k);
    for (int i = 0; i < 26; i++) begin
      if (plain_sc[i] == k) return (i == 7 || i == 8 || i == 12) ? -1 : i + 1;
    end
    return -1;
  endfunction

  function automatic int lk_ext(input logic [7:0] k);
    for (int i = 0; i < 10; i++) if (ext_tab[i] == k) return 'h90 + i;
    return -1;
  endfunction

  function automatic int decode(input logic [7:0] b[$]);
    int n = b.size();
    if (n == 5 && b[0] == 8'hE0 && b[2] == 8'hE0 && b[3] == 8'hF0 && b[4] == b[1])
      return lk_ext(b[1]);
    if (n == 6 && (b[0] == 8'h12 || b[0] == 8'h14) && b[2] == 8'hF0 && b[3] == b[1] &&
        b[4] == 8'hF0 && b[5] == b[0])
      return (b[0] == 8'h12) ? lk_shift(b[1]) : lk_ctrl(b[1]);
    if (n == 3 && b[1] == 8'hF0 && b[2] == b[0]) return lk_plain(b[0]);
    return -1;
  endfunction

  // Called at a falling edge: records the byte that transfers on the next rising edge.
  task automatic sample_hs(inout int nb);
    if (sc_valid && sc_ready) begin
      nb++;
      cap_q.push_back(sc);
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sc_extra got=%0h exp=none", sc);
        end else begin
          check("sc_byte", sc, exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic drain(inout int nb, output int rdy_at, output int unm);
    rdy_at = 0;
    unm = 0;
    for (int c = 1; c <= 80; c++) begin
      if (rand_bp) sc_ready = ($urandom_range(0, 3) != 0);
      sample_hs(nb);
      if (unmapped) unm++;
      if (ascii_ready) begin
        rdy_at = c;
        break;
      end
      @(negedge clk);
    end
    sc_ready = 1'b1;
    if (rdy_at == 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=busy exp=ready");
    end
  endtask

  task automatic run_char(input logic [7:0] ch, output int nb, output int rdy_at, output int unm);
    nb = 0;
    ascii = ch;
    ascii_valid = 1'b1;
    @(negedge clk);
    ascii_valid = 1'b0;
    ascii = 8'($urandom_range(0, 255));
    drain(nb, rdy_at, unm);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, rdy, unm;
    vec_t v;

    vecs[0]  = {8'h61, 3'd3, 48'h1C_F0_1C_00_00_00};
    vecs[1]  = {8'h41, 3'd6, 48'h12_1C_F0_1C_F0_12};
    vecs[2]  = {8'h03, 3'd6, 48'h14_21_F0_21_F0_14};
    vecs[3]  = {8'h90, 3'd5, 48'hE0_75_E0_F0_75_00};
    vecs[4]  = {8'hA1, 3'd3, 48'h05_F0_05_00_00_00};
    vecs[5]  = {8'h0D, 3'd3, 48'h5A_F0_5A_00_00_00};
    vecs[6]  = {8'h7E, 3'd6, 48'h12_0E_F0_0E_F0_12};
    vecs[7]  = {8'h20, 3'd3, 48'h29_F0_29_00_00_00};
    vecs[8]  = {8'hAC, 3'd3, 48'h07_F0_07_00_00_00};
    vecs[9]  = {8'h1A, 3'd6, 48'h14_1A_F0_1A_F0_14};
    vecs[10] = {8'h7F, 3'd3, 48'h71_F0_71_00_00_00};
    vecs[11] = {8'h99, 3'd5, 48'hE0_71_E0_F0_71_00};
    vecs[12] = {8'h09, 3'd3, 48'h0D_F0_0D_00_00_00};
    vecs[13] = {8'h3F, 3'd6, 48'h12_4A_F0_4A_F0_12};
    vecs1[0] = {8'h41, 3'd2, 48'h12_1C_00_00_00_00};
    vecs1[1] = {8'h61, 3'd1, 48'h1C_00_00_00_00_00};
    vecs1[2] = {8'h90, 3'd2, 48'hE0_75_00_00_00_00};

    rst = 1'b1;
    ascii = 8'h00; ascii_valid = 1'b0; sc_ready = 1'b1;
    ascii1 = 8'h00; ascii_valid1 = 1'b0; sc_ready1 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sc_valid", sc_valid, 0);
    check("rst_sc", sc, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_unmapped", unmapped, 0);
    check("rst_ready", ascii_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_after", ascii_ready, 1);
    check("rst_state", state_dbg, 0);

    // Table of full sequences with back-to-back sc_ready.
    for (int i = 0; i < 14; i++) begin
      v = vecs[i];
      for (int j = 0; j < int'(v.len); j++) exp_q.push_back(v.b[5 - j]);
      run_char(v.ch, nb, rdy, unm);
      check("vec_nbytes", nb, v.len);
      check("vec_ready_lat", rdy, v.len + 1);
      check("vec_unmapped", unm, 0);
      check("vec_leftover", exp_q.size(), 0);
      exp_q.delete();
    end

    // Back-pressure at step 1: F0 must hold and no new character is taken.
    exp_q.push_back(8'h15); exp_q.push_back(8'hF0); exp_q.push_back(8'h15);
    nb = 0;
    ascii = 8'h71; ascii_valid = 1'b1;
    @(negedge clk);
    ascii_valid = 1'b0;
    sample_hs(nb);
    @(negedge clk);
    check("hold_step1", sc, 8'hF0);
    sc_ready = 1'b0;
    ascii = 8'h62; ascii_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_sc", sc, 8'hF0);
      check("hold_valid", sc_valid, 1);
      check("hold_ready", ascii_ready, 0);
    end
    sc_ready = 1'b1;
    ascii_valid = 1'b0;
    drain(nb, rdy, unm);
    check("hold_nbytes", nb, 3);
    check("hold_leftover", exp_q.size(), 0);

    // Unmapped character: one-cycle pulse, next character accepted immediately.
    ascii = 8'h80; ascii_valid = 1'b1;
    @(negedge clk);
    check("unm_pulse", unmapped, 1);
    check("unm_sc_valid", sc_valid, 0);
    check("unm_ready", ascii_ready, 1);
    check("unm_busy", busy, 0);
    ascii = 8'h62;
    exp_q.push_back(8'h32); exp_q.push_back(8'hF0); exp_q.push_back(8'h32);
    @(negedge clk);
    ascii_valid = 1'b0;
    check("unm_pulse_end", unmapped, 0);
    check("unm_next_busy", busy, 1);
    nb = 0;
    drain(nb, rdy, unm);
    check("unm_next_nbytes", nb, 3);
    check("unm_next_leftover", exp_q.size(), 0);

    // Reset in the middle of a SHIFT sequence.
    exp_q.push_back(8'h12); exp_q.push_back(8'h1C);
    nb = 0;
    ascii = 8'h41; ascii_valid = 1'b1;
    @(negedge clk);
    ascii_valid = 1'b0;
    sample_hs(nb);
    @(negedge clk);
    sample_hs(nb);
    @(negedge clk);
    check("mid_rst_pre_sc", sc, 8'hF0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_sc_valid", sc_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sc", sc, 8'h00);
    check("mid_rst_ready", ascii_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_after", ascii_ready, 1);
    check("mid_rst_idle", sc_valid, 0);
    check("mid_rst_leftover", exp_q.size(), 0);

    // Make-only variant with a three-cycle idle gap.
    for (int i = 0; i < 3; i++) begin
      v = vecs1[i];
      ascii1 = v.ch; ascii_valid1 = 1'b1;
      @(negedge clk);
      ascii_valid1 = 1'b0;
      for (int j = 0; j < int'(v.len); j++) begin
        check("nb_valid", sc_valid1, 1);
        check("nb_byte", sc1, v.b[5 - j]);
        @(negedge clk);
      end
      for (int g = 0; g < 3; g++) begin
        check("gap_ready", ascii_ready1, 0);
        check("gap_sc_valid", sc_valid1, 0);
        check("gap_busy", busy1, 1);
        @(negedge clk);
      end
      check("gap_done_ready", ascii_ready1, 1);
    end

    // Every byte value through the encoder, decoded back with the reference tables.
    sb_on = 1'b0;
    rand_bp = 1'b1;
    for (int i = 0; i < 256; i++) begin
      cap_q.delete();
      run_char(8'(i), nb, rdy, unm);
      if (is_mapped(8'(i))) begin
        check("rt_decode", decode(cap_q), i);
        check("rt_unm", unm, 0);
      end else begin
        check("rt_unm_pulse", unm, 1);
        check("rt_nbytes", nb, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
